gac_reduce_tree_pipe: RTL and testbench

GAC_REDUCE_TREE_PIPE -- requirements
Module: gac_reduce_tree_pipe

---
 rtl/gac_reduce_pkg.sv | 57 +++++
 rtl/gac_reduce_stage.sv | 88 ++++++++
 rtl/gac_reduce_tree_pipe.sv | 65 ++++++
 tb/tb_gac_reduce_tree_pipe.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/gac_reduce_pkg.sv
// Shared op encoding and tree-shape helpers for the gac_reduce_tree_pipe pipelined reduction tree.
package gac_reduce_pkg;

   typedef enum logic [1:0] {
      OP_OR   = 2'b00,
      OP_AND  = 2'b01,
      OP_XOR  = 2'b10,
      OP_XNOR = 2'b11
   } op_e;

   function automatic int calc_depth(input int n);
      return $clog2(n);
   endfunction

   function automatic int calc_nstg(input int depth, input int lvl_per_stg);
      return (depth + lvl_per_stg - 1) / lvl_per_stg;
   endfunction

   // Width of the tree after k levels; an odd element passes through, hence the round-up.
   function automatic int level_width(input int n, input int k);
      int w;
      w = n;
      for (int i = 0; i < k; i++) begin
         w = (w + 1) / 2;
      end
      return w;
   endfunction

   function automatic int level_offset(input int n, input int k);
      int off;
      off = 0;
      for (int j = 0; j < k; j++) begin
         off += level_width(n, j);
      end
      return off;
   endfunction

   function automatic int stage_level(input int s, input int lvl_per_stg, input int depth);
      return (s * lvl_per_stg < depth) ? s * lvl_per_stg : depth;
   endfunction

   function automatic int bnd_width(input int n, input int s, input int lvl_per_stg,
                                    input int depth);
      return level_width(n, stage_level(s, lvl_per_stg, depth));
   endfunction

   function automatic int bnd_offset(input int n, input int s, input int lvl_per_stg,
                                     input int depth);
      int off;
      off = 0;
      for (int j = 0; j < s; j++) begin
         off += bnd_width(n, j, lvl_per_stg, depth);
      end
      return off;
   endfunction

endpackage

// File: rtl/gac_reduce_stage.sv
// One pipeline stage of the reduction tree: N_LVL gate levels feeding a valid/op/data register.
// XOR/XNOR gates exist only when GAC_REDUCE_XOR_EN is defined; otherwise in_op[1] is ignored.
module gac_reduce_stage
   import gac_reduce_pkg::*;
#(
   parameter int W_IN    = 2,
   parameter int W_OUT   = 1,
   parameter int N_LVL   = 1,
   parameter bit IS_LAST = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W_IN-1:0]  in_data,
   input  logic [1:0]       in_op,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W_OUT-1:0] out_data,
   output logic [1:0]       out_op
);

   localparam int NODES    = level_offset(W_IN, N_LVL + 1);
   localparam int OFF_LAST = level_offset(W_IN, N_LVL);

   function automatic logic combine(input logic [1:0] op, input logic a, input logic b);
`ifdef GAC_REDUCE_XOR_EN
      if (op[1]) begin
         return a ^ b;
      end
`endif
      return op[0] ? (a & b) : (a | b);
   endfunction

   logic [NODES-1:0] node;
   logic [W_OUT-1:0] reduced;
   logic [W_OUT-1:0] next_data;
   logic             valid_q;
   logic [W_OUT-1:0] data_q;
   logic [1:0]       op_q;

   assign node[W_IN-1:0] = in_data;

   // Every level's nodes are packed back to back so all bits are driven and consumed.
   for (genvar k = 0; k < N_LVL; k++) begin : g_lvl
      localparam int WK    = level_width(W_IN, k);
      localparam int WN    = level_width(W_IN, k + 1);
      localparam int OFF_K = level_offset(W_IN, k);
      localparam int OFF_N = level_offset(W_IN, k + 1);
      for (genvar i = 0; i < WN; i++) begin : g_node
         if (2 * i + 1 < WK) begin : g_pair
            assign node[OFF_N+i] = combine(in_op, node[OFF_K+2*i], node[OFF_K+2*i+1]);
         end else begin : g_pass
            assign node[OFF_N+i] = node[OFF_K+2*i];
         end
      end
   end

   assign reduced = node[OFF_LAST +: W_OUT];

`ifdef GAC_REDUCE_XOR_EN
   // XNOR travels as an XOR tree and is inverted once, just before the output register.
   assign next_data = reduced ^ {W_OUT{IS_LAST && (op_e'(in_op) == OP_XNOR)}};
`else
   assign next_data = reduced;
`endif

   assign in_ready = !valid_q || out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         op_q    <= OP_OR;
      end else if (in_ready) begin
         valid_q <= in_valid;
         if (in_valid) begin
            data_q <= next_data;
            op_q   <= in_op;
         end
      end
   end

   assign out_valid = valid_q;
   assign out_data  = data_q;
   assign out_op    = op_q;

endmodule

// File: rtl/gac_reduce_tree_pipe.sv
// Pipelined balanced OR/AND(/XOR/XNOR) reduction of N_IN bits with valid/ready flow control.
// Optional macro GAC_REDUCE_XOR_EN enables the XOR and XNOR ops.
module gac_reduce_tree_pipe
   import gac_reduce_pkg::*;
#(
   parameter int N_IN        = 6,
   parameter int LVL_PER_STG = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [N_IN-1:0] in_data,
   input  logic [1:0]      in_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_z
);

   localparam int DEPTH = calc_depth(N_IN);
   localparam int NSTG  = calc_nstg(DEPTH, LVL_PER_STG);
   localparam int BUS_W = bnd_offset(N_IN, NSTG + 1, LVL_PER_STG, DEPTH);

   logic [NSTG:0]     valid_chain;
   logic [NSTG:0]     ready_chain;
   logic [2*NSTG+1:0] op_chain;
   logic [BUS_W-1:0]  data_bus;

   assign valid_chain[0]    = in_valid;
   assign op_chain[1:0]     = in_op;
   assign data_bus[N_IN-1:0] = in_data;
   assign in_ready          = ready_chain[0];
   assign ready_chain[NSTG] = out_ready;
   assign out_valid         = valid_chain[NSTG];
   assign out_z             = data_bus[BUS_W-1];

   // Stage s covers tree levels [s*LVL_PER_STG, (s+1)*LVL_PER_STG), clipped to DEPTH.
   for (genvar s = 0; s < NSTG; s++) begin : g_stg
      localparam int LV_A  = stage_level(s, LVL_PER_STG, DEPTH);
      localparam int LV_B  = stage_level(s + 1, LVL_PER_STG, DEPTH);
      localparam int W_I   = level_width(N_IN, LV_A);
      localparam int W_O   = level_width(N_IN, LV_B);
      localparam int OFF_I = bnd_offset(N_IN, s, LVL_PER_STG, DEPTH);
      localparam int OFF_O = bnd_offset(N_IN, s + 1, LVL_PER_STG, DEPTH);

      gac_reduce_stage #(
         .W_IN   (W_I),
         .W_OUT  (W_O),
         .N_LVL  (LV_B - LV_A),
         .IS_LAST(s == NSTG - 1)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .in_valid (valid_chain[s]),
         .in_ready (ready_chain[s]),
         .in_data  (data_bus[OFF_I +: W_I]),
         .in_op    (op_chain[2*s +: 2]),
         .out_valid(valid_chain[s+1]),
         .out_ready(ready_chain[s+1]),
         .out_data (data_bus[OFF_O +: W_O]),
         .out_op   (op_chain[2*s+2 +: 2])
      );
   end

endmodule

// File: tb/tb_gac_reduce_tree_pipe.sv
// Directed self-checking bench: a 6-input/1-level-per-stage pipe and a 7-input/2-level pipe.
module tb_gac_reduce_tree_pipe;

   logic       clk;
   logic       rst;

   logic       a_in_valid;
   logic       a_in_ready;
   logic [5:0] a_in_data;
   logic [1:0] a_in_op;
   logic       a_out_valid;
   logic       a_out_ready;
   logic       a_out_z;

   logic       b_in_valid;
   logic       b_in_ready;
   logic [6:0] b_in_data;
   logic [1:0] b_in_op;
   logic       b_out_valid;
   logic       b_out_ready;
   logic       b_out_z;

   int checks;
   int errors;

   gac_reduce_tree_pipe #(.N_IN(6), .LVL_PER_STG(1)) u_dut_a (
      .clk(clk), .rst(rst),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_op(a_in_op),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .out_z(a_out_z)
   );

   gac_reduce_tree_pipe #(.N_IN(7), .LVL_PER_STG(2)) u_dut_b (
      .clk(clk), .rst(rst),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_op(b_in_op),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .out_z(b_out_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      #1;
      checks += 4;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_valid got %b want 0", a_out_valid); end
      if (a_out_z !== 1'b0) begin errors++; $display("[TB] FAIL rst_out_z got %b want 0", a_out_z); end
      if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL rst_in_ready got %b want 1", a_in_ready); end
      if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL rst_b_out_valid got %b want 0", b_out_valid); end
      step();
      step();
      rst = 1'b0;
      a_out_ready = 1'b1;
   endtask

   task automatic test_basic();
      a_in_valid = 1'b1; a_in_data = 6'b000100; a_in_op = 2'b00;
      step();
      a_in_data = 6'b000000; a_in_op = 2'b00;
      step();
      a_in_valid = 1'b0; a_in_data = 6'b111111; a_in_op = 2'b01;
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid got %b want 0", a_out_valid); end
      step();
      checks += 2;
      if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_lat3_valid got %b want 1", a_out_valid); end
      if (a_out_z !== 1'b1) begin errors++; $display("[TB] FAIL basic_or_one got %b want 1", a_out_z); end
      step();
      checks += 2;
      if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_second_valid got %b want 1", a_out_valid); end
      if (a_out_z !== 1'b0) begin errors++; $display("[TB] FAIL basic_or_zero got %b want 0", a_out_z); end
      step();
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_drained got %b want 0", a_out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [5:0] vd [3];
      logic       ez [3];
      vd[0] = 6'b111111; vd[1] = 6'b111110; vd[2] = 6'b111111;
      ez[0] = 1'b1;      ez[1] = 1'b0;      ez[2] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = vd[i]; a_in_op = 2'b01;
         step();
      end
      a_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks += 2;
         if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid[%0d] got %b want 1", i, a_out_valid); end
         if (a_out_z !== ez[i]) begin errors++; $display("[TB] FAIL b2b_z[%0d] got %b want %b", i, a_out_z, ez[i]); end
         step();
      end
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL b2b_drained got %b want 0", a_out_valid); end
   endtask

   task automatic test_backpressure();
      logic [5:0] vd [4];
      logic [1:0] vo [4];
      logic       ez [4];
      logic       exp_q [$];
      int         idx;
      int         accepted;
      int         popped;
      logic       want;
      vd[0] = 6'b100000; vo[0] = 2'b00; ez[0] = 1'b1;
      vd[1] = 6'b101111; vo[1] = 2'b01; ez[1] = 1'b0;
      vd[2] = 6'b111111; vo[2] = 2'b01; ez[2] = 1'b1;
      vd[3] = 6'b000000; vo[3] = 2'b00; ez[3] = 1'b0;
      idx = 0; accepted = 0; popped = 0;
      for (int cyc = 0; cyc < 14; cyc++) begin
         a_out_ready = (cyc >= 5);
         a_in_valid  = (idx < 4);
         if (idx < 4) begin
            a_in_data = vd[idx]; a_in_op = vo[idx];
         end
         #1;
         if (cyc == 3 || cyc == 4) begin
            checks += 3;
            if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL bp_full_ready c%0d got %b want 0", cyc, a_in_ready); end
            if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid c%0d got %b want 1", cyc, a_out_valid); end
            if (a_out_z !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_z c%0d got %b want 1", cyc, a_out_z); end
         end
         if (cyc == 4) begin
            checks++;
            if (accepted != 3) begin errors++; $display("[TB] FAIL bp_accepted got %0d want 3", accepted); end
         end
         if (cyc == 5) begin
            checks++;
            if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_pop_push_ready got %b want 1", a_in_ready); end
         end
         if (cyc >= 5 && cyc <= 8) begin
            checks++;
            if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_bubble c%0d got %b want 1", cyc, a_out_valid); end
         end
         if (a_out_valid && a_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++; $display("[TB] FAIL bp_extra_result c%0d got z=%b want none", cyc, a_out_z);
            end else begin
               want = exp_q.pop_front();
               if (a_out_z !== want) begin errors++; $display("[TB] FAIL bp_order #%0d got %b want %b", popped, a_out_z, want); end
            end
            popped++;
         end
         if (a_in_valid && a_in_ready) begin
            exp_q.push_back(ez[idx]);
            idx++;
            accepted++;
         end
         step();
      end
      a_in_valid = 1'b0;
      checks += 2;
      if (popped != 4) begin errors++; $display("[TB] FAIL bp_popped got %0d want 4", popped); end
      if (exp_q.size() != 0) begin errors++; $display("[TB] FAIL bp_leftover got %0d want 0", exp_q.size()); end
   endtask

   task automatic test_xor();
      logic [5:0] vd [3];
      logic [1:0] vo [3];
      logic       ez [3];
`ifdef GAC_REDUCE_XOR_EN
      vd[0] = 6'b101100; vo[0] = 2'b10; ez[0] = 1'b1;
      vd[1] = 6'b101100; vo[1] = 2'b11; ez[1] = 1'b0;
      vd[2] = 6'b101101; vo[2] = 2'b11; ez[2] = 1'b1;
`else
      vd[0] = 6'b000001; vo[0] = 2'b10; ez[0] = 1'b1;
      vd[1] = 6'b111110; vo[1] = 2'b11; ez[1] = 1'b0;
      vd[2] = 6'b000000; vo[2] = 2'b10; ez[2] = 1'b0;
`endif
      a_out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         a_in_valid = 1'b1; a_in_data = vd[i]; a_in_op = vo[i];
         step();
      end
      a_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks += 2;
         if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL xop_valid[%0d] got %b want 1", i, a_out_valid); end
         if (a_out_z !== ez[i]) begin errors++; $display("[TB] FAIL xop_z[%0d] got %b want %b", i, a_out_z, ez[i]); end
         step();
      end
      checks++;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL xop_drained got %b want 0", a_out_valid); end
   endtask

   task automatic test_reset_flush();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 6'b111111; a_in_op = 2'b01;
      step();
      step();
      a_in_valid = 1'b0;
      step();
      checks++;
      if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL flush_pre_valid got %b want 1", a_out_valid); end
      rst = 1'b1;
      #1;
      checks += 3;
      if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %b want 0", a_out_valid); end
      if (a_out_z !== 1'b0) begin errors++; $display("[TB] FAIL flush_z got %b want 0", a_out_z); end
      if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready got %b want 1", a_in_ready); end
      step();
      rst = 1'b0;
      a_out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL flush_ghost c%0d got %b want 0", i, a_out_valid); end
      end
      checks++;
      if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL flush_ready_after got %b want 1", a_in_ready); end
   endtask

   task automatic test_odd_width();
      logic [6:0] vd [3];
      logic [1:0] vo [3];
      logic       ez [3];
      vd[0] = 7'b1111111; vo[0] = 2'b01; ez[0] = 1'b1;
      vd[1] = 7'b0111111; vo[1] = 2'b01; ez[1] = 1'b0;
      vd[2] = 7'b1000000; vo[2] = 2'b00; ez[2] = 1'b1;
      b_out_ready = 1'b1;
      b_in_valid = 1'b1; b_in_data = vd[0]; b_in_op = vo[0];
      step();
      checks++;
      if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL odd_early_valid got %b want 0", b_out_valid); end
      b_in_data = vd[1]; b_in_op = vo[1];
      step();
      b_in_data = vd[2]; b_in_op = vo[2];
      for (int i = 0; i < 3; i++) begin
         checks += 2;
         if (b_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL odd_valid[%0d] got %b want 1", i, b_out_valid); end
         if (b_out_z !== ez[i]) begin errors++; $display("[TB] FAIL odd_z[%0d] got %b want %b", i, b_out_z, ez[i]); end
         step();
         b_in_valid = 1'b0;
      end
      checks++;
      if (b_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL odd_drained got %b want 0", b_out_valid); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      a_in_valid = 1'b0; a_in_data = '0; a_in_op = 2'b00; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_in_data = '0; b_in_op = 2'b00; b_out_ready = 1'b1;
      test_reset();
      test_basic();
      test_back_to_back();
      test_backpressure();
      test_xor();
      test_reset_flush();
      test_odd_width();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
